// File: rtl/avalon_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package avalon_multi_timer_pkg;

    localparam logic [2:0] OFS_STATUS   = 3'd0;
    localparam logic [2:0] OFS_CONTROL  = 3'd1;
    localparam logic [2:0] OFS_PERIOD   = 3'd2;
    localparam logic [2:0] OFS_SNAP     = 3'd3;
    localparam logic [2:0] OFS_PRESCALE = 3'd4;
    localparam logic [2:0] OFS_PENDING  = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int STS_TO  = 0;
    localparam int STS_RUN = 1;

endpackage

// File: rtl/avalon_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, period/snapshot/control registers
// and the sticky timeout flag.
module avalon_multi_timer_channel
    import avalon_multi_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_snap,
    input  logic             wr_prescale,
    input  logic [31:0]      writedata,
    output logic [1:0]       status,
    output logic [3:0]       control,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale,
    output logic             pending
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [PRE_W-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             run_q, run_d, to_q, to_d, zero_q, zero_d, reload_q, reload_d;
    logic             start, stop, tick, cnt_zero, one_shot_done;

    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        ctrl_d     = ctrl_q;
        run_d      = run_q;
        to_d       = to_q;

        start         = wr_control & writedata[CTL_START];
        stop          = wr_control & writedata[CTL_STOP];
        cnt_zero      = (cnt_q == '0);
        tick          = run_q && (pre_cnt_q == prescale_q);
        one_shot_done = run_q && cnt_zero && !ctrl_q[CTL_CONT];
        zero_d        = cnt_zero;
        reload_d      = wr_period;

        if (run_q)
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        if (start || stop || wr_period)
            pre_cnt_d = '0;

        // A one-shot that has reached 0 parks there instead of reloading.
        if (reload_q) begin
            cnt_d = period_q;
            run_d = 1'b0;
        end else if (tick && !one_shot_done) begin
            cnt_d = cnt_zero ? period_q : cnt_q - CNT_W'(1);
        end
        if (!reload_q && one_shot_done)
            run_d = 1'b0;
        if (stop)
            run_d = 1'b0;
        if (start)
            run_d = 1'b1;

        if (wr_control)  ctrl_d     = writedata[3:0];
        if (wr_period)   period_d   = writedata[CNT_W-1:0];
        if (wr_prescale) prescale_d = writedata[PRE_W-1:0];
        if (wr_snap)     snap_d     = cnt_q;

        // Set beats clear so a timeout coinciding with a status write survives.
        if (wr_status)             to_d = 1'b0;
        if (cnt_zero && !zero_q)   to_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= RST_VAL;
            period_q   <= RST_VAL;
            snap_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            ctrl_q     <= '0;
            run_q      <= 1'b0;
            to_q       <= 1'b0;
            zero_q     <= (RESET_PERIOD == 0);
            reload_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            ctrl_q     <= ctrl_d;
            run_q      <= run_d;
            to_q       <= to_d;
            zero_q     <= zero_d;
            reload_q   <= reload_d;
        end
    end

    assign status   = {run_q, to_q};
    assign control  = ctrl_q;
    assign period   = period_q;
    assign snap     = snap_q;
    assign prescale = prescale_q;
    assign pending  = to_q & ctrl_q[CTL_ITO];

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, registered read mux,
// pending vector and combined interrupt.
module avalon_multi_timer
    import avalon_multi_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W      = 3 + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        ofs;
    logic              ch_valid, wr_en;
    logic [31:0]       readdata_q, readdata_d;
    logic [NUM_CH-1:0] pend;

    logic [1:0]       sts [NUM_CH];
    logic [3:0]       ctl [NUM_CH];
    logic [CNT_W-1:0] per [NUM_CH];
    logic [CNT_W-1:0] snp [NUM_CH];
    logic [PRE_W-1:0] pre [NUM_CH];

    assign ofs = address[2:0];

    generate
        if (NUM_CH > 1) begin : g_chsel
            assign ch_sel = address[ADDR_W-1:3];
        end else begin : g_chsel_single
            assign ch_sel = 1'b0;
        end
        if (NUM_CH == (1 << CH_W)) begin : g_full
            assign ch_valid = 1'b1;
        end else begin : g_partial
            assign ch_valid = (32'(ch_sel) < NUM_CH);
        end
    endgenerate

    assign wr_en = chipselect & ~write_n & ch_valid;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic wr_ch;
            assign wr_ch = wr_en && (ch_sel == CH_W'(g));

            avalon_multi_timer_channel #(
                .CNT_W        (CNT_W),
                .PRE_W        (PRE_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_ch (
                .clk         (clk),
                .reset_n     (reset_n),
                .wr_status   (wr_ch && (ofs == OFS_STATUS)),
                .wr_control  (wr_ch && (ofs == OFS_CONTROL)),
                .wr_period   (wr_ch && (ofs == OFS_PERIOD)),
                .wr_snap     (wr_ch && (ofs == OFS_SNAP)),
                .wr_prescale (wr_ch && (ofs == OFS_PRESCALE)),
                .writedata   (writedata),
                .status      (sts[g]),
                .control     (ctl[g]),
                .period      (per[g]),
                .snap        (snp[g]),
                .prescale    (pre[g]),
                .pending     (pend[g])
            );
        end
    endgenerate

    // The mux registers every cycle; chipselect only gates writes.
    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (ofs)
                    OFS_STATUS:   readdata_d = 32'(sts[i]);
                    OFS_CONTROL:  readdata_d = 32'(ctl[i]);
                    OFS_PERIOD:   readdata_d = 32'(per[i]);
                    OFS_SNAP:     readdata_d = 32'(snp[i]);
                    OFS_PRESCALE: readdata_d = 32'(pre[i]);
                    OFS_PENDING:  readdata_d = 32'(pend);
                    default:      readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_q <= '0;
        else
            readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |pend;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer with hand-computed expectations.
module tb_avalon_multi_timer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;
    logic [31:0] rv;

    avalon_multi_timer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] adr(input int ch, input int ofs);
        return 5'((ch << 3) | ofs);
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        d = readdata;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        for (int i = 0; i < budget && !irq; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, {31'b0, irq}, 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        rd(adr(0, 2), rv); check("rst_ch0_period", rv, 32'd49999);
        rd(adr(0, 0), rv); check("rst_ch0_status", rv, 32'd0);
        rd(adr(0, 5), rv); check("rst_pending", rv, 32'd0);
        wr(adr(0, 6), 32'hFFFF_FFFF);
        rd(adr(0, 6), rv); check("ofs6_reads_0", rv, 32'd0);

        // ch1: continuous, period 9, prescale 0 -> timeout every 10 clocks
        wr(adr(1, 2), 32'd9);
        wr(adr(1, 4), 32'd0);
        wr(adr(1, 1), 32'h7);
        t0 = cyc;
        wait_irq("ch1_irq_first", 40);
        check("ch1_first_to_delay", 32'(cyc - t0), 32'd10);
        rd(adr(1, 5), rv); check("ch1_pending", rv, 32'h2);
        rd(adr(3, 5), rv); check("pending_alias_ch3", rv, 32'h2);
        rd(adr(1, 0), rv); check("ch1_status_run_to", rv, 32'h3);
        wr(adr(1, 0), 32'd0);
        check("ch1_irq_cleared", {31'b0, irq}, 32'd0);
        wait_irq("ch1_irq_second", 40);
        check("ch1_second_to_delay", 32'(cyc - t0), 32'd20);
        wr(adr(1, 1), 32'h8);
        wr(adr(1, 0), 32'd0);
        check("ch1_irq_after_stop", {31'b0, irq}, 32'd0);
        rd(adr(1, 1), rv); check("ch1_control_readback", rv, 32'h8);

        // ch2: one-shot, period 3, prescale 4 -> steps every 5 clocks
        wr(adr(2, 2), 32'd3);
        wr(adr(2, 4), 32'd4);
        wr(adr(2, 1), 32'h5);
        t0 = cyc;
        repeat (5) @(posedge clk);
        wr(adr(2, 3), 32'd0);
        rd(adr(2, 3), rv); check("ch2_snap_after_first_step", rv, 32'd2);
        rd(adr(2, 4), rv); check("ch2_prescale", rv, 32'd4);
        wait_irq("ch2_irq", 40);
        check("ch2_to_delay", 32'(cyc - t0), 32'd16);
        rd(adr(2, 0), rv); check("ch2_status_oneshot_done", rv, 32'h1);
        repeat (12) @(posedge clk);
        wr(adr(2, 3), 32'd0);
        rd(adr(2, 3), rv); check("ch2_no_reload", rv, 32'd0);
        wr(adr(2, 1), 32'h0);
        wr(adr(2, 0), 32'd0);

        // ch0: period write mid-count forces reload and stops
        wr(adr(0, 2), 32'd100);
        wr(adr(0, 1), 32'h4);
        repeat (5) @(posedge clk);
        wr(adr(0, 2), 32'd20);
        @(posedge clk);
        wr(adr(0, 3), 32'd0);
        rd(adr(0, 3), rv); check("ch0_snap_reloaded", rv, 32'd20);
        rd(adr(0, 0), rv); check("ch0_run_cleared", rv, 32'd0);
        rd(adr(0, 2), rv); check("ch0_period", rv, 32'd20);

        // ch3: timeout event coincides with a STATUS write
        wr(adr(3, 2), 32'd4);
        wr(adr(3, 4), 32'd0);
        wr(adr(3, 1), 32'h7);
        repeat (4) @(posedge clk);
        wr(adr(3, 0), 32'd0);
        check("ch3_irq_kept", {31'b0, irq}, 32'd1);
        rd(adr(3, 0), rv); check("ch3_to_kept", rv, 32'h3);
        wr(adr(3, 1), 32'h8);
        wr(adr(3, 0), 32'd0);
        check("ch3_irq_after_clear", {31'b0, irq}, 32'd0);
        wr(adr(3, 1), 32'hC);
        rd(adr(3, 0), rv); check("ch3_start_wins_stop", {31'b0, rv[1]}, 32'd1);

        // reset mid-count with irq asserted
        wr(adr(1, 1), 32'h7);
        wait_irq("ch1_irq_before_reset", 40);
        rd(adr(1, 2), rv); check("ch1_period_before_reset", rv, 32'd9);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(adr(1, 2), rv); check("post_rst_ch1_period", rv, 32'd49999);
        rd(adr(1, 0), rv); check("post_rst_ch1_status", rv, 32'd0);
        rd(adr(1, 1), rv); check("post_rst_ch1_control", rv, 32'd0);
        rd(adr(2, 4), rv); check("post_rst_ch2_prescale", rv, 32'd0);
        rd(adr(2, 3), rv); check("post_rst_ch2_snap", rv, 32'd0);
        rd(adr(0, 5), rv); check("post_rst_pending", rv, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
